// File: rtl/soc_top_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | soc_top_if : SPI pin bundle between an external master and soc_top         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface soc_top_if;
  logic i_CSn;
  logic i_SCLK;
  logic i_MOSI;
  logic o_MISO;

  modport master (output i_CSn, output i_SCLK, output i_MOSI, input o_MISO);
  modport slave  (input i_CSn, input i_SCLK, input i_MOSI, output o_MISO);
endinterface
`default_nettype wire

// File: rtl/soc_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | soc_top : SPI boot-loader for a word-addressed IMEM plus an 8-bit GPIO reg |
// | Option  : SOC_TOP_READBACK_EN builds the IMEM read command (0x01)          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module soc_top #(
  parameter int DEPTH = 512
) (
  input  wire        i_clk,
  input  wire        globalRST,
  input  wire        PROG,
  soc_top_if.slave   spi,
  output logic [7:0] GPIO_out
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    ST_CMD    = 3'd0,
    ST_WRITE  = 3'd1,
    ST_READ   = 3'd2,
    ST_GPIO   = 3'd3,
    ST_IGNORE = 3'd4
  } state_t;

  logic          csn_s1_q, csn_s2_q, csn_s3_q;
  logic          sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic          mosi_s1_q, mosi_s2_q;
  logic          boot_mode_q;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    rx_q, rx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [23:0]   word_q, word_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic          load_done_q, load_done_d;
  logic [7:0]    gpio_q, gpio_d;
  logic          miso_q, miso_d;

  logic          sclk_rise, sclk_fall, cs_fall;
  logic [7:0]    rx_byte;
  logic [31:0]   full_word;
  logic [7:0]    tx_byte;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   imem [DEPTH];

`ifdef SOC_TOP_READBACK_EN
  logic          mem_re;
  logic [31:0]   mem_rdata_q;
  logic          rd_pend_q, rd_pend_d;
  logic [31:0]   rd_word_q, rd_word_d;
`endif

  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
  assign cs_fall   = ~csn_s2_q & csn_s3_q;
  assign rx_byte   = {rx_q, mosi_s2_q};
  assign full_word = {rx_byte, word_q};

  assign spi.o_MISO = miso_q;
  assign GPIO_out   = gpio_q;

  // Byte presented on MISO for the byte currently being shifted.
  always_comb begin
    tx_byte = 8'h00;
    case (state_q)
      ST_CMD:  tx_byte = {boot_mode_q, load_done_q, 6'b0};
`ifdef SOC_TOP_READBACK_EN
      ST_READ: tx_byte = rd_word_q[8*byte_idx_q +: 8];
`endif
      default: tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    wptr_d      = wptr_q;
    load_done_d = load_done_q;
    gpio_d      = gpio_q;
    miso_d      = miso_q;
    mem_we      = 1'b0;
    mem_addr    = wptr_q;
    mem_wdata   = full_word;
`ifdef SOC_TOP_READBACK_EN
    mem_re      = 1'b0;
    rd_pend_d   = 1'b0;
    rd_word_d   = rd_pend_q ? mem_rdata_q : rd_word_q;
`endif

    if (csn_s2_q) begin
      state_d    = ST_CMD;
      bit_cnt_d  = 3'd0;
      rx_d       = 7'd0;
      byte_idx_d = 2'd0;
      word_d     = 24'd0;
      miso_d     = 1'b0;
`ifdef SOC_TOP_READBACK_EN
      rd_word_d  = 32'd0;
`endif
    end else begin
      // MSB of each byte is shown before its first rise; later bits follow falls.
      if (cs_fall) begin
        miso_d = tx_byte[7];
      end else if (sclk_fall) begin
        miso_d = tx_byte[~bit_cnt_q];
      end

      if (sclk_rise) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        rx_d      = rx_byte[6:0];
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            ST_CMD: begin
              byte_idx_d = 2'd0;
              word_d     = 24'd0;
              if (rx_byte == 8'h02 && boot_mode_q) begin
                state_d = ST_WRITE;
                wptr_d  = '0;
              end
`ifdef SOC_TOP_READBACK_EN
              else if (rx_byte == 8'h01) begin
                state_d = ST_READ;
              end
`endif
              else if (rx_byte == 8'h03 && !boot_mode_q) begin
                state_d = ST_GPIO;
              end else begin
                state_d = ST_IGNORE;
              end
            end
            ST_WRITE, ST_READ: begin
              byte_idx_d = byte_idx_q + 2'd1;
              word_d     = {rx_byte, word_q[23:8]};
              if (byte_idx_q == 2'd3) begin
                if (state_q == ST_WRITE) begin
                  if (full_word == 32'hFFFF_FFFF) begin
                    load_done_d = 1'b1;
                    state_d     = ST_IGNORE;
                  end else begin
                    mem_we = 1'b1;
                    wptr_d = wptr_q + AW'(1);
                  end
                end
`ifdef SOC_TOP_READBACK_EN
                else begin
                  mem_re    = 1'b1;
                  mem_addr  = full_word[AW+1:2];
                  rd_pend_d = 1'b1;
                end
`endif
              end
            end
            ST_GPIO: begin
              gpio_d  = rx_byte;
              state_d = ST_IGNORE;
            end
            default: state_d = ST_IGNORE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge globalRST) begin
    if (globalRST) begin
      csn_s1_q    <= 1'b1;
      csn_s2_q    <= 1'b1;
      csn_s3_q    <= 1'b1;
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_s3_q   <= 1'b0;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      state_q     <= ST_CMD;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 7'd0;
      byte_idx_q  <= 2'd0;
      word_q      <= 24'd0;
      wptr_q      <= '0;
      load_done_q <= 1'b0;
      gpio_q      <= 8'h00;
      miso_q      <= 1'b0;
`ifdef SOC_TOP_READBACK_EN
      rd_pend_q   <= 1'b0;
      rd_word_q   <= 32'd0;
`endif
    end else begin
      csn_s1_q    <= spi.i_CSn;
      csn_s2_q    <= csn_s1_q;
      csn_s3_q    <= csn_s2_q;
      sclk_s1_q   <= spi.i_SCLK;
      sclk_s2_q   <= sclk_s1_q;
      sclk_s3_q   <= sclk_s2_q;
      mosi_s1_q   <= spi.i_MOSI;
      mosi_s2_q   <= mosi_s1_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      wptr_q      <= wptr_d;
      load_done_q <= load_done_d;
      gpio_q      <= gpio_d;
      miso_q      <= miso_d;
`ifdef SOC_TOP_READBACK_EN
      rd_pend_q   <= rd_pend_d;
      rd_word_q   <= rd_word_d;
`endif
    end
  end

  // Boot mode is captured only while reset is held and then frozen.
  always_ff @(posedge i_clk) begin
    if (globalRST) begin
      boot_mode_q <= PROG;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      imem[mem_addr] <= mem_wdata;
    end
`ifdef SOC_TOP_READBACK_EN
    if (mem_re) begin
      mem_rdata_q <= imem[mem_addr];
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_soc_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_soc_top : randomized SPI frames against a frame-level reference model   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_soc_top;
  localparam int DEPTH = 512;
  localparam int HALF  = 6;
`ifdef SOC_TOP_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       prog;
  logic [7:0] gpio;

  soc_top_if spi_if();

  soc_top #(.DEPTH(DEPTH)) dut (
    .i_clk     (clk),
    .globalRST (rst),
    .PROG      (prog),
    .spi       (spi_if),
    .GPIO_out  (gpio)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] ref_mem   [DEPTH];
  bit          ref_valid [DEPTH];
  int          valid_q[$];
  bit          m_boot, m_done;
  logic [7:0]  m_gpio;

  logic [7:0]  txb  [256];
  logic [7:0]  rxb  [256];
  logic [7:0]  expb [256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] get_word(input int k);
    return {txb[4+4*k], txb[3+4*k], txb[2+4*k], txb[1+4*k]};
  endfunction

  task automatic put_word(input int k, input logic [31:0] w);
    for (int b = 0; b < 4; b++) txb[1+4*k+b] = w[8*b +: 8];
  endtask

  function automatic logic [31:0] addr_of(input int idx);
    logic [31:0] a;
    a = $urandom;
    a = (a & ~((DEPTH-1) << 2)) | (32'(idx) << 2);
    return a;
  endfunction

  task automatic mem_write(input int p, input logic [31:0] w);
    ref_mem[p] = w;
    if (!ref_valid[p]) begin
      ref_valid[p] = 1'b1;
      valid_q.push_back(p);
    end
  endtask

  // Expected MISO bytes and model side effects of one whole frame.
  task automatic model_frame(input int n);
    int          nw;
    int          ptr;
    logic [31:0] w;
    for (int i = 0; i < n; i++) expb[i] = 8'h00;
    expb[0] = {m_boot, m_done, 6'b0};
    nw = (n - 1) / 4;
    case (txb[0])
      8'h02: if (m_boot) begin
        ptr = 0;
        for (int k = 0; k < nw; k++) begin
          w = get_word(k);
          if (w == 32'hFFFF_FFFF) begin
            m_done = 1'b1;
            break;
          end
          mem_write(ptr, w);
          ptr = (ptr + 1) % DEPTH;
        end
      end
      8'h01: if (RB) begin
        for (int k = 1; 1 + 4*k < n; k++) begin
          w = ref_mem[(get_word(k-1) >> 2) % DEPTH];
          for (int b = 0; b < 4 && 1 + 4*k + b < n; b++) expb[1+4*k+b] = w[8*b +: 8];
        end
      end
      8'h03: if (!m_boot && n >= 2) m_gpio = txb[1];
      default: ;
    endcase
  endtask

  task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi_if.i_MOSI = tx[i];
      repeat (HALF) @(negedge clk);
      spi_if.i_SCLK = 1'b1;
      rx[i] = spi_if.o_MISO;
      repeat (HALF) @(negedge clk);
      spi_if.i_SCLK = 1'b0;
    end
  endtask

  task automatic run_frame(input string tag, input int n);
    logic [7:0] r;
    model_frame(n);
    spi_if.i_CSn = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      spi_xfer(txb[i], r);
      rxb[i] = r;
    end
    repeat (HALF) @(negedge clk);
    spi_if.i_CSn = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < n; i++) chk($sformatf("%s_miso%0d", tag, i), 32'(rxb[i]), 32'(expb[i]));
  endtask

  task automatic check_mem(input string tag);
    foreach (valid_q[j]) chk($sformatf("%s_imem%0d", tag, valid_q[j]), dut.imem[valid_q[j]], ref_mem[valid_q[j]]);
  endtask

  task automatic apply_reset(input bit p);
    @(negedge clk);
    prog = p;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    rst  = 1'b0;
    m_boot = p;
    m_done = 1'b0;
    m_gpio = 8'h00;
    repeat (4) @(negedge clk);
  endtask

  task automatic build_read(input int nwords, output int n);
    txb[0] = 8'h01;
    for (int k = 0; k < nwords; k++) put_word(k, addr_of(valid_q[$urandom_range(0, valid_q.size()-1)]));
    put_word(nwords, $urandom);
    n = 1 + 4*(nwords + 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          sel;
    logic [7:0]  r;
    rst = 1'b1;
    prog = 1'b1;
    spi_if.i_CSn = 1'b1;
    spi_if.i_SCLK = 1'b0;
    spi_if.i_MOSI = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_valid[i] = 1'b0;

    apply_reset(1'b1);
    chk("rst_gpio", 32'(gpio), 32'h00);
    chk("rst_miso", 32'(spi_if.o_MISO), 32'h0);

    // Program two fixed words, six random ones, terminator, trailing junk.
    txb[0] = 8'h02;
    put_word(0, 32'h0000_0093);
    put_word(1, 32'h0010_0113);
    for (int k = 2; k < 8; k++) put_word(k, $urandom & 32'h7FFF_FFFF);
    put_word(8, 32'hFFFF_FFFF);
    txb[37] = 8'($urandom);
    txb[38] = 8'($urandom);
    run_frame("prog", 39);
    check_mem("prog");

    txb[0] = 8'h55; txb[1] = 8'($urandom); txb[2] = 8'($urandom);
    run_frame("status_done", 3);

    txb[0] = 8'h03; txb[1] = 8'hA7;
    run_frame("gpio_boot", 2);
    chk("gpio_boot_locked", 32'(gpio), 32'(m_gpio));

    // Readback after reset: IMEM survives, load_done is cleared.
    apply_reset(1'b1);
    check_mem("after_rst");
    txb[0] = 8'h01;
    put_word(0, 32'h0);
    put_word(1, 32'h4);
    put_word(2, 32'h8);
    for (int k = 3; k < 8; k++) put_word(k, addr_of(valid_q[$urandom_range(0, valid_q.size()-1)]));
    put_word(8, $urandom);
    run_frame("readback", 37);

    // Aborted write keeps IMEM; next write restarts at index 0.
    txb[0] = 8'h02; txb[1] = 8'h11; txb[2] = 8'h22;
    run_frame("abort", 3);
    check_mem("abort");
    txb[0] = 8'h02;
    put_word(0, $urandom & 32'h7FFF_FFFF);
    put_word(1, $urandom & 32'h7FFF_FFFF);
    put_word(2, 32'hFFFF_FFFF);
    run_frame("rewrite", 13);
    check_mem("rewrite");

    // Run mode: GPIO writes allowed, IMEM writes locked out.
    apply_reset(1'b0);
    txb[0] = 8'h03; txb[1] = 8'h5A; txb[2] = 8'h33;
    run_frame("gpio", 3);
    chk("gpio_5a", 32'(gpio), 32'(m_gpio));
    txb[0] = 8'h02;
    put_word(0, $urandom);
    put_word(1, $urandom);
    run_frame("lockout", 9);
    check_mem("lockout");

    for (int f = 0; f < 8; f++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: build_read($urandom_range(1, 3), n);
        1: begin
          txb[0] = 8'h02;
          put_word(0, $urandom);
          n = 5;
        end
        2: begin
          txb[0] = 8'h03;
          n = $urandom_range(2, 4);
          for (int i = 1; i < n; i++) txb[i] = 8'($urandom);
        end
        default: begin
          txb[0] = 8'hA5 ^ 8'($urandom_range(0, 1) << 7);
          n = $urandom_range(1, 5);
          for (int i = 1; i < n; i++) txb[i] = 8'($urandom);
        end
      endcase
      run_frame($sformatf("rnd%0d", f), n);
      chk($sformatf("rnd%0d_gpio", f), 32'(gpio), 32'(m_gpio));
    end
    check_mem("rnd");

    // Reset mid-read: outputs clear at once, IMEM persists.
    txb[0] = 8'h03; txb[1] = 8'hC3;
    run_frame("gpio_pre", 2);
    chk("gpio_pre_val", 32'(gpio), 32'h0000_00C3);
    spi_if.i_CSn = 1'b0;
    repeat (6) @(negedge clk);
    spi_xfer(8'h01, r);
    for (int b = 0; b < 4; b++) spi_xfer(8'(addr_of(valid_q[0]) >> (8*b)), r);
    spi_xfer(8'h00, r);
    rst = 1'b1;
    #1;
    chk("midrst_miso", 32'(spi_if.o_MISO), 32'h0);
    chk("midrst_gpio", 32'(gpio), 32'h00);
    spi_if.i_CSn = 1'b1;
    repeat (3) @(negedge clk);
    prog = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_boot = 1'b0;
    m_done = 1'b0;
    m_gpio = 8'h00;
    repeat (4) @(negedge clk);
    check_mem("midrst");
    build_read(3, n);
    run_frame("post_rst_read", n);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
